// File: rtl/boot_loader_if.sv
// -----------------------------------------------------------------------------
// boot_loader_if
// Groups the byte-stream handshake and the instruction-memory write bus of the
// boot loader.
//   rx_data    [7:0]  incoming byte (source -> loader)
//   rx_valid          rx_data valid this cycle (source -> loader)
//   rx_ready          loader accepts a byte this cycle (loader -> source)
//   imem_we           one-cycle write strobe per assembled word (loader -> memory)
//   imem_addr  [31:0] byte address of the write (loader -> memory)
//   imem_wdata [31:0] assembled little-endian word (loader -> memory)
// Modports: slave = boot loader side, master = byte source / memory side.
// -----------------------------------------------------------------------------
interface boot_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );
endinterface

// File: rtl/boot_loader.sv
// -----------------------------------------------------------------------------
// boot_loader
// Holds the RV32 core in reset while a byte stream (4-byte little-endian word
// count LEN, then LEN little-endian payload words) is written into instruction
// memory from byte address 0, then releases the core.
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   bus         boot_loader_if.slave: rx_data/rx_valid/rx_ready byte stream and
//               imem_we/imem_addr/imem_wdata write port
//   reload      restart loading; honoured only in RUN or ERR
//   core_hold   1 keeps the core in reset
//   done        program loaded, core running
//   error       load aborted
//   word_count  words written so far
// Optional feature: define BOOT_LOADER_CHECKSUM_EN to add a trailing checksum
// byte; the modulo-256 sum of all header, payload and checksum bytes must be 0.
// All outputs are registered; flag outputs are decoded from the next state.
// -----------------------------------------------------------------------------
module boot_loader #(
  parameter int MAX_WORDS = 1024,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  boot_loader_if.slave     bus,
  input  logic             reload,
  output logic             core_hold,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] word_count
);

  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_DATA  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_RUN   = 3'd3,
`ifdef BOOT_LOADER_CHECKSUM_EN
    ST_ERR   = 3'd4,
    ST_CSUM  = 3'd5
`else
    ST_ERR   = 3'd4
`endif
  } state_t;

  // State entered once the payload (or an empty header) has been consumed.
`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam state_t ST_END = ST_CSUM;
`else
  localparam state_t ST_END = ST_DRAIN;
`endif

  state_t            state_r;
  state_t            state_nxt_s;

  logic [1:0]        byte_idx_r;
  logic [1:0]        byte_idx_nxt_s;
  logic [31:0]       buf_r;
  logic [31:0]       buf_nxt_s;
  logic [31:0]       len_r;
  logic [31:0]       len_nxt_s;
  logic [CNT_W-1:0]  word_count_r;
  logic [CNT_W-1:0]  word_count_nxt_s;

  logic              rx_ready_r;
  logic              rx_ready_nxt_s;
  logic              imem_we_r;
  logic              imem_we_nxt_s;
  logic [31:0]       imem_addr_r;
  logic [31:0]       imem_addr_nxt_s;
  logic [31:0]       imem_wdata_r;
  logic [31:0]       imem_wdata_nxt_s;
  logic              core_hold_r;
  logic              core_hold_nxt_s;
  logic              done_r;
  logic              done_nxt_s;
  logic              error_r;
  logic              error_nxt_s;

  logic              accept_s;
  logic              last_byte_s;
  logic              last_word_s;
  logic [31:0]       word_s;

  // Byte k of a word lands in bits [8k+7:8k]: shift right, new byte on top.
  assign accept_s    = bus.rx_valid & rx_ready_r;
  assign last_byte_s = accept_s & (byte_idx_r == 2'd3);
  assign word_s      = {bus.rx_data, buf_r[31:8]};
  assign last_word_s = ((32'(word_count_r) + 32'd1) == len_r);

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [7:0] sum_r;
  logic [7:0] sum_nxt_s;
  logic [7:0] sum_s;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data);
    return acc + data;
  endfunction

  assign sum_s = csum_add(sum_r, bus.rx_data);

  // Running modulo-256 sum of every accepted byte; cleared on reload.
  always_comb begin
    sum_nxt_s = sum_r;
    if (accept_s) begin
      sum_nxt_s = sum_s;
    end else if (((state_r == ST_RUN) || (state_r == ST_ERR)) && reload) begin
      sum_nxt_s = 8'd0;
    end else begin
      sum_nxt_s = sum_r;
    end
  end

  // Checksum accumulator register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_r <= 8'd0;
    end else begin
      sum_r <= sum_nxt_s;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_HDR;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_HDR: begin
        if (last_byte_s) begin
          if (word_s > 32'(MAX_WORDS)) begin
            state_nxt_s = ST_ERR;
          end else if (word_s == 32'd0) begin
            state_nxt_s = ST_END;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          state_nxt_s = ST_HDR;
        end
      end
      ST_DATA: begin
        if (last_byte_s && last_word_s) begin
          state_nxt_s = ST_END;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (accept_s) begin
          state_nxt_s = (sum_s == 8'd0) ? ST_DRAIN : ST_ERR;
        end else begin
          state_nxt_s = ST_CSUM;
        end
      end
`endif
      ST_DRAIN: begin
        state_nxt_s = ST_RUN;
      end
      ST_RUN, ST_ERR: begin
        if (reload) begin
          state_nxt_s = ST_HDR;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = ST_HDR;
      end
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    byte_idx_nxt_s   = byte_idx_r;
    buf_nxt_s        = buf_r;
    len_nxt_s        = len_r;
    word_count_nxt_s = word_count_r;
    imem_we_nxt_s    = 1'b0;
    imem_addr_nxt_s  = imem_addr_r;
    imem_wdata_nxt_s = imem_wdata_r;
    case (state_r)
      ST_HDR: begin
        if (accept_s) begin
          byte_idx_nxt_s = byte_idx_r + 2'd1;
          buf_nxt_s      = word_s;
          if (byte_idx_r == 2'd3) begin
            len_nxt_s = word_s;
          end else begin
            len_nxt_s = len_r;
          end
        end else begin
          byte_idx_nxt_s = byte_idx_r;
        end
      end
      ST_DATA: begin
        if (accept_s) begin
          byte_idx_nxt_s = byte_idx_r + 2'd1;
          buf_nxt_s      = word_s;
          if (byte_idx_r == 2'd3) begin
            imem_we_nxt_s    = 1'b1;
            imem_wdata_nxt_s = word_s;
            imem_addr_nxt_s  = 32'(word_count_r) << 2;
            word_count_nxt_s = word_count_r + CNT_W'(1);
          end else begin
            imem_we_nxt_s = 1'b0;
          end
        end else begin
          byte_idx_nxt_s = byte_idx_r;
        end
      end
      ST_RUN, ST_ERR: begin
        // Memory contents and the last write address/data are left alone.
        if (reload) begin
          byte_idx_nxt_s   = 2'd0;
          buf_nxt_s        = 32'd0;
          len_nxt_s        = 32'd0;
          word_count_nxt_s = '0;
        end else begin
          byte_idx_nxt_s = byte_idx_r;
        end
      end
      default: begin
        byte_idx_nxt_s = byte_idx_r;
      end
    endcase

    // Flags follow the state being entered so they line up with it exactly.
`ifdef BOOT_LOADER_CHECKSUM_EN
    rx_ready_nxt_s  = (state_nxt_s == ST_HDR) || (state_nxt_s == ST_DATA) ||
                      (state_nxt_s == ST_CSUM);
`else
    rx_ready_nxt_s  = (state_nxt_s == ST_HDR) || (state_nxt_s == ST_DATA);
`endif
    core_hold_nxt_s = (state_nxt_s != ST_RUN);
    done_nxt_s      = (state_nxt_s == ST_RUN);
    error_nxt_s     = (state_nxt_s == ST_ERR);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx_r   <= 2'd0;
      buf_r        <= 32'd0;
      len_r        <= 32'd0;
      word_count_r <= '0;
      rx_ready_r   <= 1'b1;
      imem_we_r    <= 1'b0;
      imem_addr_r  <= 32'd0;
      imem_wdata_r <= 32'd0;
      core_hold_r  <= 1'b1;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      byte_idx_r   <= byte_idx_nxt_s;
      buf_r        <= buf_nxt_s;
      len_r        <= len_nxt_s;
      word_count_r <= word_count_nxt_s;
      rx_ready_r   <= rx_ready_nxt_s;
      imem_we_r    <= imem_we_nxt_s;
      imem_addr_r  <= imem_addr_nxt_s;
      imem_wdata_r <= imem_wdata_nxt_s;
      core_hold_r  <= core_hold_nxt_s;
      done_r       <= done_nxt_s;
      error_r      <= error_nxt_s;
    end
  end

  assign bus.rx_ready   = rx_ready_r;
  assign bus.imem_we    = imem_we_r;
  assign bus.imem_addr  = imem_addr_r;
  assign bus.imem_wdata = imem_wdata_r;
  assign core_hold      = core_hold_r;
  assign done           = done_r;
  assign error          = error_r;
  assign word_count     = word_count_r;

endmodule

// File: tb/tb_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_boot_loader
// Scoreboard bench for boot_loader: expected memory writes are queued as the
// word's last byte is driven and popped when imem_we is seen. Inputs change on
// the falling edge, outputs are sampled on the falling edge.
// Also covers the checksum variant when BOOT_LOADER_CHECKSUM_EN is defined.
// -----------------------------------------------------------------------------
module tb_boot_loader;
  localparam int MAX_WORDS = 1024;
  localparam int CNT_W     = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             reload;
  logic             core_hold;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] word_count;

  boot_loader_if bus ();

  boot_loader #(.MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset_n),
    .bus        (bus),
    .reload     (reload),
    .core_hold  (core_hold),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] sb_q[$];
  logic [63:0] exp_w;
  logic [31:0] prog [0:7];
  logic [7:0]  sum_acc;
  int          ready_low;
  bit          reload_in_gap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_we", bus.imem_addr, 32'hFFFF_FFFF);
      end else begin
        exp_w = sb_q.pop_front();
        check("we_addr", bus.imem_addr, exp_w[63:32]);
        check("we_data", bus.imem_wdata, exp_w[31:0]);
      end
    end
  end

  // Drive one byte at a falling edge, wait for acceptance, then idle 'gap' cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.rx_ready !== 1'b1) check("ready_timeout", 32'(bus.rx_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    sum_acc      = sum_acc + b;
    bus.rx_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      bus.rx_data = 8'($urandom);
      reload      = reload_in_gap;
      if (bus.rx_ready !== 1'b1) ready_low++;
      @(negedge clk);
    end
    reload = 1'b0;
  endtask

  task automatic push_word(input int w, input logic [31:0] data);
    logic [31:0] addr;
    addr = 32'(w) * 32'd4;
    sb_q.push_back({addr, data});
  endtask

  // Full stream: header n, words prog[0..n-1], checksum byte when enabled.
  task automatic load_words(input int n, input int gap);
    logic [31:0] len;
    bit          tail;
    len     = 32'(n);
    sum_acc = 8'd0;
    for (int i = 0; i < 4; i++) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
      tail = 1'b0;
`else
      tail = (n == 0) && (i == 3);
`endif
      send_byte(len[8*i +: 8], tail ? 0 : gap);
    end
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
        tail = 1'b0;
`else
        tail = (w == n - 1) && (k == 3);
`endif
        if (k == 3) push_word(w, prog[w]);
        send_byte(prog[w][8*k +: 8], tail ? 0 : gap);
      end
    end
`ifdef BOOT_LOADER_CHECKSUM_EN
    send_byte(8'd0 - sum_acc, 0);
`endif
  endtask

  // Called on the falling edge after the final byte's acceptance edge.
  task automatic finish_check(input int exp_wc);
    check("drain_hold",  32'(core_hold),    32'd1);
    check("drain_ready", 32'(bus.rx_ready), 32'd0);
    check("drain_done",  32'(done),         32'd0);
    @(negedge clk);
    check("run_hold",  32'(core_hold),    32'd0);
    check("run_done",  32'(done),         32'd1);
    check("run_error", 32'(error),        32'd0);
    check("run_ready", 32'(bus.rx_ready), 32'd0);
    check("run_wc",    32'(word_count),   32'(exp_wc));
    check("sb_empty",  32'(sb_q.size()),  32'd0);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("rl_hold",  32'(core_hold),    32'd1);
    check("rl_done",  32'(done),         32'd0);
    check("rl_error", 32'(error),        32'd0);
    check("rl_wc",    32'(word_count),   32'd0);
    check("rl_ready", 32'(bus.rx_ready), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(bus.rx_ready), 32'd1);
    check({tag, "_we"},    32'(bus.imem_we),  32'd0);
    check({tag, "_addr"},  bus.imem_addr,     32'd0);
    check({tag, "_wdata"}, bus.imem_wdata,    32'd0);
    check({tag, "_hold"},  32'(core_hold),    32'd1);
    check({tag, "_done"},  32'(done),         32'd0);
    check({tag, "_error"}, 32'(error),        32'd0);
    check({tag, "_wc"},    32'(word_count),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'd0;
    reload        = 1'b0;
    reload_in_gap = 1'b0;
    ready_low     = 0;
    sum_acc       = 8'd0;
    reset_n       = 1'b0;
    prog[0] = 32'h0000_0513;
    prog[1] = 32'h0010_0593;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    reset_n = 1'b1;
    @(negedge clk);

    // 1: two words, back-to-back bytes.
    load_words(2, 0);
    finish_check(2);
    do_reload();

    // 2: three idle cycles between bytes; reload during loading is ignored.
    ready_low     = 0;
    reload_in_gap = 1'b1;
    load_words(2, 3);
    reload_in_gap = 1'b0;
    check("gap_ready_low", 32'(ready_low), 32'd0);
    finish_check(2);
    do_reload();

    // 3: empty program.
    load_words(0, 0);
    finish_check(0);
    do_reload();

    // 4: LEN = MAX_WORDS+1 aborts; reload recovers.
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("err_error", 32'(error),        32'd1);
    check("err_ready", 32'(bus.rx_ready), 32'd0);
    check("err_hold",  32'(core_hold),    32'd1);
    @(negedge clk);
    check("err_stay",  32'(error),        32'd1);
    do_reload();
    prog[0] = 32'h1234_5678;
    load_words(1, 0);
    finish_check(1);
    do_reload();

    // LEN = MAX_WORDS is accepted; reload in DATA is ignored; then abort by reset.
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("max_error", 32'(error),        32'd0);
    check("max_ready", 32'(bus.rx_ready), 32'd1);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("max_rl_ready", 32'(bus.rx_ready), 32'd1);
    check("max_rl_hold",  32'(core_hold),    32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 5: reset after two bytes of the second word.
    prog[0] = 32'h0000_0513;
    prog[1] = 32'h0010_0593;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) push_word(0, prog[0]);
      send_byte(prog[0][8*k +: 8], 0);
    end
    send_byte(prog[1][7:0], 0);
    send_byte(prog[1][15:8], 0);
    reset_n = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    load_words(2, 0);
    finish_check(2);
    do_reload();

`ifdef BOOT_LOADER_CHECKSUM_EN
    // 6: good checksum runs, bad checksum errors with the word still written.
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h05, 0);
    send_byte(8'h00, 0);
    push_word(0, 32'h0000_0513);
    send_byte(8'h00, 0);
    send_byte(8'hE7, 0);
    finish_check(1);
    do_reload();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h05, 0);
    send_byte(8'h00, 0);
    push_word(0, 32'h0000_0513);
    send_byte(8'h00, 0);
    send_byte(8'hE8, 0);
    check("csum_error", 32'(error),        32'd1);
    check("csum_hold",  32'(core_hold),    32'd1);
    check("csum_ready", 32'(bus.rx_ready), 32'd0);
    check("csum_wc",    32'(word_count),   32'd1);
    check("csum_sb",    32'(sb_q.size()),  32'd0);
    do_reload();
`endif

    repeat (2) @(negedge clk);
    check("final_sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Upstream feeder for the single-cycle RV32 core.
- Holds the core in reset and receives a byte stream over a valid/ready interface (typically from a UART receiver).
- Assembles the stream into little-endian 32-bit words and writes them sequentially into instruction memory from byte address 0.
- Releases the core once the declared program length has been written.

Parameters:
- MAX_WORDS, 1024: largest accepted program length, in words.
- CNT_W, 16: width of the word counter and of the word_count output.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous active-low reset; 0 = reset.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid this cycle.
- rx_ready  output  1  loader accepts a byte this cycle.
- reload  input  1  restart loading; honoured only in RUN or ERR.
- imem_we  output  1  instruction-memory write strobe, one-cycle pulse per word.
- imem_addr  output  32  byte address of the write (word index * 4).
- imem_wdata  output  32  assembled word.
- core_hold  output  1  1 keeps the core in reset.
- done  output  1  program loaded, core running.
- error  output  1  load aborted.
- word_count  output  CNT_W  words written so far.

Behaviour:
- Reset values (reset=0, asynchronous):
  - state = HDR.
  - rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0.
  - core_hold=1, done=0, error=0, word_count=0.
  - Byte index and length registers cleared.
- Byte accept: a byte transfers when rx_valid && rx_ready at the clock edge. No transfer when rx_valid=0. rx_data is ignored when not transferring.
- State HDR:
  - Accept 4 bytes forming LEN, little-endian (first byte -> LEN[7:0]).
  - On the 4th byte:
    - LEN > MAX_WORDS -> ERR.
    - LEN = 0 -> DRAIN (or CSUM if enabled).
    - else -> DATA.
- State DATA:
  - Bytes fill a 32-bit shift buffer; byte k of a word goes to bits [8k+7:8k].
  - On the 4th byte of a word (cycle N), at edge N+1 the registers imem_wdata, imem_addr=word_count*4 and imem_we=1 are loaded. The pulse lasts exactly one cycle; word_count increments in the same edge.
  - rx_ready stays 1 during the write pulse, so back-to-back bytes every cycle are supported with no stall.
  - On the final byte of word LEN-1, the next state is DRAIN (or CSUM if enabled).
- State DRAIN:
  - One cycle; rx_ready=0. The final imem_we pulse is visible here.
  - Next edge: RUN.
- State RUN:
  - core_hold=0, done=1, rx_ready=0.
  - Latency: the final payload byte accepted at cycle N gives imem_we at N+1 and core_hold=0 at N+2.
- State ERR:
  - error=1, core_hold=1, rx_ready=0, no writes.
- reload=1 in RUN or ERR:
  - Next edge: HDR, core_hold=1, done=0, error=0.
  - word_count and the buffers are cleared.
  - Instruction-memory contents are not cleared.
  - reload in any other state is ignored.
- Reset asserted mid-word or mid-write:
  - Immediate return to reset values; any pending imem_we is cancelled.
  - A partial word is discarded.
- Arithmetic:
  - imem_addr = {word_count, 2'b00}, zero-extended to 32 bits.
  - word_count never exceeds LEN, so no wrap can occur.

Optional Feature:
- Macro: BOOT_LOADER_CHECKSUM_EN.
- Defined:
  - A state CSUM follows the last payload word (or the header if LEN=0) and accepts one trailing byte.
  - A modulo-256 sum covers all header, payload and checksum bytes.
  - Sum == 0 -> DRAIN, then RUN.
  - Sum != 0 -> ERR. Words already written remain in memory, and core_hold stays 1.
- Not defined: no CSUM state, no sum logic, and the stream ends at the last payload byte.

Test Plan:
1. Two-word load, bytes streamed one per cycle: 02 00 00 00 13 05 00 00 93 05 10 00 -> imem_we pulses with (addr 0x0, data 0x00000513) and (addr 0x4, data 0x00100593); core_hold falls 2 cycles after the last byte; done=1; word_count=2.
2. Same stream with rx_valid deasserted for 3 cycles between every byte -> identical writes and values; rx_ready=1 throughout the load.
3. Header 00 00 00 00 -> no imem_we; RUN 2 cycles after the 4th header byte.
4. Header declaring MAX_WORDS+1 (0x401 with MAX_WORDS=1024) -> ERR; error=1, rx_ready=0, core_hold=1. Then reload=1, followed by a valid one-word stream -> loads and runs.
5. reset=0 after 2 bytes of the second payload word -> all outputs return to reset values with no further imem_we. A fresh full stream then loads correctly from address 0.
6. With BOOT_LOADER_CHECKSUM_EN: stream 01 00 00 00 13 05 00 00 then checksum E7 -> RUN. Same stream with checksum E8 -> ERR, core_hold=1, and the word at address 0 is still written.
